// File: rtl/puf_seq_pkg.sv
// Shared types and constants for the PUF challenge sequencer.
// VOTE_REPS and vote_majority are used only when PUF_SEQ_VOTE_EN is defined.
package puf_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int VOTE_REPS = 3;

    // Majority of three votes given the count of ones
    function automatic logic vote_majority(input logic [1:0] ones);
        return (ones >= 2'd2);
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Control/response and engine-side signals of the PUF challenge sequencer.
// master = environment (controller + engine); slave = sequencer.
interface puf_challenge_sequencer_if #(
    parameter int CHAL_W = 6,
    parameter int N_RESP = 16
);
    logic              start;
    logic              abort;
    logic [CHAL_W-1:0] base_chal;
    logic              busy;
    logic              resp_valid;
    logic [N_RESP-1:0] resp;
    logic              resp_ack;
    logic              err;
    logic              meas_en;
    logic              meas_start;
    logic [CHAL_W-1:0] meas_chal;
    logic              meas_done;
    logic              meas_gt;

    modport master (
        output start, abort, base_chal, resp_ack, meas_done, meas_gt,
        input  busy, resp_valid, resp, err, meas_en, meas_start, meas_chal
    );

    modport slave (
        input  start, abort, base_chal, resp_ack, meas_done, meas_gt,
        output busy, resp_valid, resp, err, meas_en, meas_start, meas_chal
    );
endinterface

// File: rtl/puf_seq_watchdog.sv
// Saturating per-measurement timeout counter; expired marks the last allowed WAIT cycle.
module puf_seq_watchdog #(
    parameter int TIMEOUT = 2**28
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SAT   = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;

    // Counter: clear has priority, then count up to saturation
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && (cnt_r != SAT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign expired = (cnt_r == LIMIT);
endmodule

// File: rtl/puf_challenge_sequencer.sv
// Steps the RO-pair PUF engine over N_RESP challenges and assembles the response word.
// Optional PUF_SEQ_VOTE_EN: three measurements per challenge, majority vote per bit.
module puf_challenge_sequencer
    import puf_seq_pkg::*;
#(
    parameter int CHAL_W    = 6,
    parameter int N_RESP    = 16,
    parameter int CHAL_STEP = 1,
    parameter int TIMEOUT   = 2**28
) (
    input logic                     clk,
    input logic                     rst,
    puf_challenge_sequencer_if.slave bus
);
    localparam int IDX_W = (N_RESP > 1) ? $clog2(N_RESP) : 1;

    state_t            state_r, state_nxt_s;
    logic [CHAL_W-1:0] chal_r;
    logic [IDX_W-1:0]  idx_r;
    logic [N_RESP-1:0] resp_r;
    logic              err_r, gt_r;
    logic              busy_r, resp_valid_r, meas_en_r, meas_start_r;
    logic              abort_s, accept_s, capture_s, timeout_s, store_s;
    logic              last_idx_s, bit_final_s, vote_bit_s;
    logic              wd_clr_s, wd_en_s, wd_expired_s;

    assign abort_s    = bus.abort && (state_r != IDLE);
    assign last_idx_s = (idx_r == IDX_W'(N_RESP - 1));
    assign wd_clr_s   = (state_r == ISSUE);
    assign wd_en_s    = (state_r == WAIT);

    puf_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .expired (wd_expired_s)
    );

`ifdef PUF_SEQ_VOTE_EN
    logic [1:0] rep_r, ones_r;

    assign bit_final_s = (rep_r == 2'(VOTE_REPS - 1));
    assign vote_bit_s  = vote_majority(ones_r + {1'b0, gt_r});

    // Vote accumulation across the repeated measurements of one challenge
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            rep_r  <= 2'd0;
            ones_r <= 2'd0;
        end else if (store_s) begin
            if (bit_final_s) begin
                rep_r  <= 2'd0;
                ones_r <= 2'd0;
            end else begin
                rep_r  <= rep_r + 2'd1;
                ones_r <= ones_r + {1'b0, gt_r};
            end
        end
    end
`else
    assign bit_final_s = 1'b1;
    assign vote_bit_s  = gt_r;
`endif

    // Next-state and per-cycle strobes; abort from any busy state takes priority
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        timeout_s   = 1'b0;
        store_s     = 1'b0;
        if (abort_s) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ISSUE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ISSUE: state_nxt_s = WAIT;
                WAIT: begin
                    if (bus.meas_done) begin
                        capture_s   = 1'b1;
                        state_nxt_s = STORE;
                    end else if (wd_expired_s) begin
                        timeout_s   = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
                STORE: begin
                    store_s = 1'b1;
                    if (bit_final_s && last_idx_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = ISSUE;
                    end
                end
                DONE: begin
                    if (bus.resp_ack) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register and outputs decoded from the next state so they leave flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            meas_en_r    <= 1'b0;
            meas_start_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= (state_nxt_s != IDLE);
            resp_valid_r <= (state_nxt_s == DONE);
            meas_en_r    <= (state_nxt_s == ISSUE) || (state_nxt_s == WAIT) || (state_nxt_s == STORE);
            meas_start_r <= (state_nxt_s == ISSUE);
        end
    end

    // Challenge, bit index, response word and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            chal_r <= {CHAL_W{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
            resp_r <= {N_RESP{1'b0}};
            err_r  <= 1'b0;
            gt_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                chal_r <= bus.base_chal;
                idx_r  <= {IDX_W{1'b0}};
                resp_r <= {N_RESP{1'b0}};
                err_r  <= 1'b0;
            end else if (store_s && bit_final_s) begin
                resp_r[idx_r] <= vote_bit_s;
                if (!last_idx_s) begin
                    idx_r  <= idx_r + IDX_W'(1);
                    chal_r <= chal_r + CHAL_W'(CHAL_STEP);
                end
            end else if (timeout_s) begin
                err_r <= 1'b1;
            end
            if (capture_s) begin
                gt_r <= bus.meas_gt;
            end
        end
    end

    assign bus.busy       = busy_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp       = resp_r;
    assign bus.err        = err_r;
    assign bus.meas_en    = meas_en_r;
    assign bus.meas_start = meas_start_r;
    assign bus.meas_chal  = chal_r;
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench: a run planner derives stimulus and expected outputs per cycle from
// the measurement schedule, then a compare process checks the DUT every cycle.
module tb_puf_challenge_sequencer;
    localparam int CHAL_W    = 6;
    localparam int N_RESP    = 4;
    localparam int CHAL_STEP = 1;
    localparam int TIMEOUT   = 16;
`ifdef PUF_SEQ_VOTE_EN
    localparam int REPS = 3;
`else
    localparam int REPS = 1;
`endif
    localparam int NMEAS = N_RESP * REPS;
    localparam int MAXC  = 8000;
    localparam int K_BUSY = 0, K_RV = 1, K_RESP = 2, K_CHAL = 3, K_ERR = 4, K_MS = 5, K_MEN = 6;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } pin_t;

    logic clk = 1'b0;
    logic rst;
    puf_challenge_sequencer_if #(.CHAL_W(CHAL_W), .N_RESP(N_RESP)) bus ();

    puf_challenge_sequencer #(
        .CHAL_W(CHAL_W), .N_RESP(N_RESP), .CHAL_STEP(CHAL_STEP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // stimulus plan per cycle
    bit                s_rst[MAXC], s_start[MAXC], s_abort[MAXC], s_ack[MAXC], s_done[MAXC], s_gt[MAXC];
    logic [CHAL_W-1:0] s_base[MAXC];
    // expected outputs per cycle
    bit                e_busy[MAXC], e_ms[MAXC], e_men[MAXC], e_rv[MAXC], e_err[MAXC];
    logic [CHAL_W-1:0] e_chal[MAXC];
    logic [N_RESP-1:0] e_resp[MAXC];
    pin_t              pins[$];

    int                p, plan_end, cyc, checks, errors;
    bit                running, cur_hold;
    logic [N_RESP-1:0] m_resp;
    bit                m_err;
    int                r_lat[NMEAS];
    bit                r_gt[NMEAS];

    task automatic add_pin(input int c, input int k, input logic [31:0] v);
        pin_t pn;
        pn.cyc = c; pn.kind = k; pn.val = v;
        pins.push_back(pn);
    endtask

    task automatic put_idle(input int c);
        e_busy[c] = 1'b0; e_ms[c] = 1'b0; e_men[c] = 1'b0; e_rv[c] = 1'b0;
        e_chal[c] = '0; e_resp[c] = m_resp; e_err[c] = m_err;
    endtask

    task automatic put_run(input int c, input bit ms, input bit men, input bit rv, input logic [CHAL_W-1:0] ch);
        e_busy[c] = 1'b1; e_ms[c] = ms; e_men[c] = men; e_rv[c] = rv;
        e_chal[c] = ch; e_resp[c] = m_resp; e_err[c] = m_err;
        s_start[c] = cur_hold;
    endtask

    task automatic plan_idle(input int n, input bit noisy);
        for (int i = 0; i < n; i++) begin
            put_idle(p);
            if (noisy) begin
                s_ack[p]   = ($urandom_range(0, 1) == 1);
                s_abort[p] = ($urandom_range(0, 3) == 0);
                s_done[p]  = ($urandom_range(0, 2) == 0);
            end
            p++;
        end
    endtask

    // One run: r_lat[k]==0 means the engine never answers measurement k
    task automatic plan_run(input logic [CHAL_W-1:0] base, input int brk_meas, input int brk_off,
                            input bit brk_rst, input bit hold, input int ackd);
        logic [CHAL_W-1:0] ch;
        int  ones, k;
        bit  to, brk;
        cur_hold = hold;
        put_idle(p); s_start[p] = 1'b1; s_base[p] = base; p++;
        m_resp = '0; m_err = 1'b0; ch = base; to = 1'b0; brk = 1'b0;
        for (int b = 0; b < N_RESP && !to && !brk; b++) begin
            ones = 0;
            for (int r = 0; r < REPS && !to && !brk; r++) begin
                k = b * REPS + r;
                put_run(p, 1'b1, 1'b1, 1'b0, ch); s_done[p] = ($urandom_range(0, 3) == 0); p++;
                if (brk_meas == k) begin
                    for (int w = 0; w < brk_off; w++) begin put_run(p, 1'b0, 1'b1, 1'b0, ch); p++; end
                    if (brk_rst) s_rst[p-1] = 1'b1; else s_abort[p-1] = 1'b1;
                    if (r_lat[k] == brk_off) begin s_done[p-1] = 1'b1; s_gt[p-1] = r_gt[k]; end
                    if (brk_rst) begin m_resp = '0; m_err = 1'b0; end
                    brk = 1'b1;
                end else if (r_lat[k] == 0) begin
                    for (int w = 0; w < TIMEOUT; w++) begin put_run(p, 1'b0, 1'b1, 1'b0, ch); p++; end
                    m_err = 1'b1;
                    to = 1'b1;
                end else begin
                    for (int w = 0; w < r_lat[k]; w++) begin put_run(p, 1'b0, 1'b1, 1'b0, ch); p++; end
                    s_done[p-1] = 1'b1; s_gt[p-1] = r_gt[k];
                    put_run(p, 1'b0, 1'b1, 1'b0, ch); s_done[p] = ($urandom_range(0, 3) == 0); p++;
                    ones += int'(r_gt[k]);
                end
            end
            if (!to && !brk) begin
                m_resp[b] = (REPS == 1) ? (ones == 1) : (ones >= 2);
                ch = ch + CHAL_W'(CHAL_STEP);
            end
        end
        if (!brk) begin
            for (int w = 0; w <= ackd; w++) begin
                put_run(p, 1'b0, 1'b0, 1'b1, ch); s_done[p] = ($urandom_range(0, 2) == 0); p++;
            end
            s_ack[p-1]   = 1'b1;
            s_abort[p-1] = ($urandom_range(0, 3) == 0);
        end
        cur_hold = 1'b0;
    endtask

    task automatic set_sched(input int lat, input logic [31:0] gts);
        for (int k = 0; k < NMEAS; k++) begin
            r_lat[k] = lat;
            r_gt[k]  = gts[k];
        end
    endtask

    task automatic apply(input int c);
        rst           = s_rst[c];
        bus.start     = s_start[c];
        bus.abort     = s_abort[c];
        bus.base_chal = s_base[c];
        bus.resp_ack  = s_ack[c];
        bus.meas_done = s_done[c];
        bus.meas_gt   = s_gt[c];
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h required %0h", nm, cyc, act, exp);
        end
    endtask

    // Compare DUT outputs with the planned expectations every cycle
    always @(negedge clk) begin
        if (running && cyc >= 1) begin
            chk("busy", 32'(bus.busy), 32'(e_busy[cyc]));
            chk("meas_start", 32'(bus.meas_start), 32'(e_ms[cyc]));
            chk("meas_en", 32'(bus.meas_en), 32'(e_men[cyc]));
            chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv[cyc]));
            chk("resp", 32'(bus.resp), 32'(e_resp[cyc]));
            chk("err", 32'(bus.err), 32'(e_err[cyc]));
            if (e_men[cyc]) chk("meas_chal", 32'(bus.meas_chal), 32'(e_chal[cyc]));
            foreach (pins[i]) begin
                if (pins[i].cyc == cyc) begin
                    case (pins[i].kind)
                        K_BUSY:  chk("pin_busy", 32'(bus.busy), pins[i].val);
                        K_RV:    chk("pin_resp_valid", 32'(bus.resp_valid), pins[i].val);
                        K_RESP:  chk("pin_resp", 32'(bus.resp), pins[i].val);
                        K_CHAL:  chk("pin_meas_chal", 32'(bus.meas_chal), pins[i].val);
                        K_ERR:   chk("pin_err", 32'(bus.err), pins[i].val);
                        K_MS:    chk("pin_meas_start", 32'(bus.meas_start), pins[i].val);
                        default: chk("pin_meas_en", 32'(bus.meas_en), pins[i].val);
                    endcase
                end
            end
        end
    end

    initial begin
        int t, bm, bo;
        running = 1'b0; cyc = 0; checks = 0; errors = 0;
        p = 0; m_resp = '0; m_err = 1'b0; cur_hold = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            s_rst[c] = 1'b0; s_start[c] = 1'b0; s_abort[c] = 1'b0; s_ack[c] = 1'b0;
            s_done[c] = 1'b0; s_gt[c] = ($urandom_range(0, 1) == 1);
            s_base[c] = CHAL_W'($urandom); put_idle(c);
        end
        // reset
        s_rst[0] = 1'b1; s_rst[1] = 1'b1; s_rst[2] = 1'b1;
        plan_idle(5, 1'b0);
        add_pin(2, K_BUSY, 0); add_pin(2, K_RESP, 0); add_pin(2, K_MEN, 0); add_pin(2, K_ERR, 0);
`ifndef PUF_SEQ_VOTE_EN
        // wrap of the challenge, latency L=5
        t = p; set_sched(5, 32'b1101);
        plan_run(6'h3E, -1, 0, 1'b0, 1'b0, 2);
        add_pin(t+1, K_CHAL, 32'h3E); add_pin(t+8, K_CHAL, 32'h3F);
        add_pin(t+15, K_CHAL, 32'h00); add_pin(t+22, K_CHAL, 32'h01);
        add_pin(t+28, K_RV, 0); add_pin(t+29, K_RV, 1); add_pin(t+29, K_RESP, 32'b1101);
        plan_idle(2, 1'b1);
        // timeout on bit 2
        t = p; set_sched(5, 32'b0011); r_lat[2] = 0;
        plan_run(6'h10, -1, 0, 1'b0, 1'b0, 1);
        add_pin(t+31, K_RV, 0); add_pin(t+32, K_RV, 1); add_pin(t+32, K_ERR, 1);
        add_pin(t+32, K_RESP, 32'b0011); add_pin(t+35, K_ERR, 1);
        plan_idle(2, 1'b1);
        // done on the exact expiry cycle
        t = p; set_sched(1, 32'b0001); r_lat[0] = TIMEOUT;
        plan_run(6'h21, -1, 0, 1'b0, 1'b0, 0);
        add_pin(t+27, K_RV, 0); add_pin(t+28, K_RV, 1); add_pin(t+28, K_ERR, 0);
        add_pin(t+28, K_RESP, 32'b0001);
        plan_idle(2, 1'b1);
`else
        // majority vote: 1,0,1 -> 1 ; 0,0,1 -> 0 ; 1,1,0 -> 1 ; 0,0,0 -> 0
        t = p; set_sched(2, 32'b000_011_100_101);
        plan_run(6'h05, -1, 0, 1'b0, 1'b0, 1);
        add_pin(t+1, K_CHAL, 32'h05); add_pin(t+9, K_CHAL, 32'h05); add_pin(t+13, K_CHAL, 32'h06);
        add_pin(t+4, K_MS, 0); add_pin(t+5, K_MS, 1);
        add_pin(t+48, K_RV, 0); add_pin(t+49, K_RV, 1); add_pin(t+49, K_RESP, 32'b0101);
        plan_idle(2, 1'b1);
`endif
        // abort during WAIT of bit 1, then start held through a run
        set_sched(3, 32'($urandom));
        plan_run(6'h2A, REPS, 2, 1'b0, 1'b0, 0);
        add_pin(p, K_BUSY, 0); add_pin(p, K_MEN, 0); add_pin(p, K_RV, 0);
        plan_idle(2, 1'b1);
        set_sched(2, 32'($urandom));
        plan_run(6'h07, -1, 0, 1'b0, 1'b1, 3);
        plan_idle(2, 1'b1);
        // reset in the middle of a run
        set_sched(4, 32'($urandom));
        plan_run(6'h19, REPS, 1, 1'b1, 1'b1, 0);
        add_pin(p, K_BUSY, 0); add_pin(p, K_RESP, 0); add_pin(p, K_MEN, 0);
        plan_idle(2, 1'b1);
        // randomized runs
        for (int n = 0; n < 30 && p < MAXC - 400; n++) begin
            for (int k = 0; k < NMEAS; k++) begin
                r_lat[k] = $urandom_range(1, 6);
                r_gt[k]  = ($urandom_range(0, 1) == 1);
            end
            if ($urandom_range(0, 6) == 0) r_lat[$urandom_range(0, NMEAS-1)] = 0;
            if ($urandom_range(0, 6) == 0) r_lat[$urandom_range(0, NMEAS-1)] = TIMEOUT;
            bm = -1; bo = 1;
            if ($urandom_range(0, 5) == 0) begin
                bm = $urandom_range(0, NMEAS-1);
                bo = (r_lat[bm] == 0) ? $urandom_range(1, TIMEOUT) : $urandom_range(1, r_lat[bm]);
            end
            plan_run(CHAL_W'($urandom), bm, bo, ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 1) == 1), $urandom_range(0, 3));
            plan_idle($urandom_range(1, 3), 1'b1);
        end
        plan_idle(3, 1'b0);
        plan_end = p;

        apply(0);
        running = 1'b1;
        while (cyc < plan_end - 1) begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            apply(cyc);
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
